// File: rtl/btn_cmd_sched.sv
// Command scheduler: captures button and UART requests into pending bits and
// issues them one at a time to the watch FSM with an enforced quiet gap.
module btn_cmd_sched #(
    parameter int GAP_CYC = 1000,
    parameter int RR_EN   = 1,
    parameter int DROP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        i_btn_pulse,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_cmd_ready,
    output logic              o_cmd_valid,
    output logic [2:0]        o_cmd_id,
    output logic              o_cmd_src,
    output logic [4:0]        o_pending,
    output logic [DROP_W-1:0] o_drop_cnt
);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t            state, state_d;
    logic [4:0]        pending, pending_d, src, src_d;
    logic [4:0]        uart_hit, req, grant_clr;
    logic [2:0]        rr_ptr, rr_ptr_d;
    logic [2:0]        grant_id, sel_start, sel_idx;
    logic [3:0]        sel_sum;
    logic              grant_any;
    logic              cmd_valid_d, cmd_src_d;
    logic [2:0]        cmd_id_d;
    logic [GW-1:0]     gap_cnt, gap_cnt_d;
    logic [DROP_W-1:0] drop_cnt, drop_cnt_d;
    logic [2:0]        drop_inc;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [2:0] b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + (DROP_W + 1)'(b);
        return s[DROP_W] ? '1 : s[DROP_W-1:0];
    endfunction

    always_comb begin
        uart_hit = '0;
        if (i_rx_valid) begin
            case (i_rx_data)
                8'h52, 8'h72: uart_hit[0] = 1'b1;
                8'h43, 8'h63: uart_hit[1] = 1'b1;
                8'h48, 8'h68: uart_hit[2] = 1'b1;
                8'h4D, 8'h6D: uart_hit[3] = 1'b1;
                8'h53, 8'h73: uart_hit[4] = 1'b1;
                default:      uart_hit    = '0;
            endcase
        end
    end

    assign req = i_btn_pulse | uart_hit;

    // Grant search starts just past the last grant (round-robin) or at 0.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        sel_sum   = '0;
        sel_idx   = '0;
        sel_start = (RR_EN != 0) ? ((rr_ptr == 3'd4) ? 3'd0 : rr_ptr + 3'd1) : 3'd0;
        for (int j = 0; j < 5; j++) begin
            sel_sum = {1'b0, sel_start} + 4'(j);
            sel_idx = (sel_sum >= 4'd5) ? 3'(sel_sum - 4'd5) : sel_sum[2:0];
            if (!grant_any && pending[sel_idx]) begin
                grant_any = 1'b1;
                grant_id  = sel_idx;
            end
        end
    end

    always_comb begin
        state_d     = state;
        cmd_valid_d = o_cmd_valid;
        cmd_id_d    = o_cmd_id;
        cmd_src_d   = o_cmd_src;
        gap_cnt_d   = gap_cnt;
        rr_ptr_d    = rr_ptr;
        grant_clr   = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    grant_clr[grant_id] = 1'b1;
                    cmd_valid_d         = 1'b1;
                    cmd_id_d            = grant_id;
                    cmd_src_d           = src[grant_id];
                    state_d             = ISSUE;
                    if (RR_EN != 0) rr_ptr_d = grant_id;
                end
            end
            ISSUE: begin
                if (i_cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    if (GAP_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GW'(GAP_CYC - 1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_d = IDLE;
                else               gap_cnt_d = gap_cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A request on a bit being granted this cycle re-arms it rather than merging.
    always_comb begin
        pending_d = pending;
        src_d     = src;
        drop_inc  = '0;
        for (int i = 0; i < 5; i++) begin
            if (req[i]) begin
                if (pending[i] && !grant_clr[i]) begin
                    drop_inc = drop_inc + 3'd1;
                end else begin
                    pending_d[i] = 1'b1;
                    src_d[i]     = ~i_btn_pulse[i];
                    if (i_btn_pulse[i] && uart_hit[i]) drop_inc = drop_inc + 3'd1;
                end
            end else if (grant_clr[i]) begin
                pending_d[i] = 1'b0;
            end
        end
        drop_cnt_d = sat_add(drop_cnt, drop_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            src         <= '0;
            rr_ptr      <= '0;
            gap_cnt     <= '0;
            drop_cnt    <= '0;
            o_cmd_valid <= 1'b0;
            o_cmd_id    <= '0;
            o_cmd_src   <= 1'b0;
        end else begin
            state       <= state_d;
            pending     <= pending_d;
            src         <= src_d;
            rr_ptr      <= rr_ptr_d;
            gap_cnt     <= gap_cnt_d;
            drop_cnt    <= drop_cnt_d;
            o_cmd_valid <= cmd_valid_d;
            o_cmd_id    <= cmd_id_d;
            o_cmd_src   <= cmd_src_d;
        end
    end

    assign o_pending  = pending;
    assign o_drop_cnt = drop_cnt;
endmodule

// File: tb/tb_btn_cmd_sched.sv
// Directed testbench for btn_cmd_sched with a short gap and round-robin grant.
module tb_btn_cmd_sched;
    localparam int GAP = 10;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    i_btn_pulse = '0;
    logic [7:0]    i_rx_data = '0;
    logic          i_rx_valid = 1'b0;
    logic          i_cmd_ready = 1'b0;
    logic          o_cmd_valid;
    logic [2:0]    o_cmd_id;
    logic          o_cmd_src;
    logic [4:0]    o_pending;
    logic [DW-1:0] o_drop_cnt;

    int n_chk = 0;
    int n_fail = 0;

    btn_cmd_sched #(.GAP_CYC(GAP), .RR_EN(1), .DROP_W(DW)) dut (
        .clk(clk), .rst(rst), .i_btn_pulse(i_btn_pulse), .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid), .i_cmd_ready(i_cmd_ready), .o_cmd_valid(o_cmd_valid),
        .o_cmd_id(o_cmd_id), .o_cmd_src(o_cmd_src), .o_pending(o_pending),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (o_cmd_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_chk++;
        if ({o_cmd_valid, o_cmd_id, o_cmd_src} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_cmd: got v=%0b id=%0d src=%0b expected all 0", o_cmd_valid, o_cmd_id, o_cmd_src);
        end
        n_chk++;
        if (o_pending !== 5'b0 || o_drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: got pend=%b drop=%0d expected 0/0", o_pending, o_drop_cnt);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_button();
        int n;
        i_cmd_ready = 1'b1;
        i_btn_pulse = 5'b00001;
        tick();
        i_btn_pulse = '0;
        n_chk++;
        if (o_pending !== 5'b00001 || o_cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pend: got pend=%b v=%0b expected 00001/0", o_pending, o_cmd_valid);
        end
        tick();
        n_chk++;
        if (o_cmd_valid !== 1'b1 || o_cmd_id !== 3'd0 || o_cmd_src !== 1'b0) begin
            n_fail++;
            $display("FAIL single_issue: got v=%0b id=%0d src=%0b expected 1/0/0", o_cmd_valid, o_cmd_id, o_cmd_src);
        end
        i_btn_pulse = 5'b00001;
        tick();
        i_btn_pulse = '0;
        n_chk++;
        if (o_cmd_valid !== 1'b0 || o_pending !== 5'b00001) begin
            n_fail++;
            $display("FAIL single_one_cycle: got v=%0b pend=%b expected 0/00001", o_cmd_valid, o_pending);
        end
        wait_valid(n);
        n_chk++;
        if (n + 1 !== GAP + 2) begin
            n_fail++;
            $display("FAIL single_spacing: got %0d cycles expected %0d", n + 1, GAP + 2);
        end
        tick();
        n_chk++;
        if (o_cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop_valid: got v=%0b expected 0", o_cmd_valid);
        end
        repeat (GAP + 2) tick();
    endtask

    task automatic test_same_cycle();
        int n;
        i_cmd_ready = 1'b0;
        i_btn_pulse = 5'b10110;
        i_rx_valid  = 1'b1;
        i_rx_data   = 8'h63;
        tick();
        i_btn_pulse = '0;
        i_rx_valid  = 1'b0;
        n_chk++;
        if (o_pending !== 5'b10110 || o_drop_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL same_capture: got pend=%b drop=%0d expected 10110/1", o_pending, o_drop_cnt);
        end
        tick();
        n_chk++;
        if (o_cmd_valid !== 1'b1 || o_cmd_id !== 3'd1 || o_cmd_src !== 1'b0) begin
            n_fail++;
            $display("FAIL same_first: got v=%0b id=%0d src=%0b expected 1/1/0", o_cmd_valid, o_cmd_id, o_cmd_src);
        end
        i_cmd_ready = 1'b1;
        tick();
        wait_valid(n);
        n_chk++;
        if (o_cmd_valid !== 1'b1 || o_cmd_id !== 3'd2) begin
            n_fail++;
            $display("FAIL same_second: got v=%0b id=%0d expected 1/2", o_cmd_valid, o_cmd_id);
        end
        tick();
        wait_valid(n);
        n_chk++;
        if (o_cmd_valid !== 1'b1 || o_cmd_id !== 3'd4) begin
            n_fail++;
            $display("FAIL same_third: got v=%0b id=%0d expected 1/4", o_cmd_valid, o_cmd_id);
        end
        tick();
        n_chk++;
        if (o_pending !== 5'b0 || o_cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL same_done: got pend=%b v=%0b expected 0/0", o_pending, o_cmd_valid);
        end
        repeat (GAP + 2) tick();
    endtask

    task automatic test_uart_hold();
        i_cmd_ready = 1'b0;
        i_rx_valid  = 1'b1;
        i_rx_data   = 8'h6D;
        tick();
        i_rx_valid  = 1'b0;
        n_chk++;
        if (o_pending !== 5'b01000) begin
            n_fail++;
            $display("FAIL uart_pend: got %b expected 01000", o_pending);
        end
        tick();
        for (int c = 0; c < 10; c++) begin
            n_chk++;
            if (o_cmd_valid !== 1'b1 || o_cmd_id !== 3'd3 || o_cmd_src !== 1'b1) begin
                n_fail++;
                $display("FAIL uart_hold[%0d]: got v=%0b id=%0d src=%0b expected 1/3/1", c, o_cmd_valid, o_cmd_id, o_cmd_src);
            end
            tick();
        end
        i_cmd_ready = 1'b1;
        tick();
        n_chk++;
        if (o_cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL uart_accept: got v=%0b expected 0", o_cmd_valid);
        end
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h41;
        tick();
        i_rx_valid = 1'b0;
        n_chk++;
        if (o_pending !== 5'b0 || o_drop_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL uart_ignore: got pend=%b drop=%0d expected 0/1", o_pending, o_drop_cnt);
        end
        repeat (GAP + 2) tick();
    endtask

    task automatic test_drop_sat();
        i_cmd_ready = 1'b0;
        i_btn_pulse = 5'b00001;
        tick();
        i_btn_pulse = '0;
        tick();
        i_btn_pulse = 5'b00001;
        tick();
        n_chk++;
        if (o_pending !== 5'b00001 || o_drop_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL drop_set: got pend=%b drop=%0d expected 00001/1", o_pending, o_drop_cnt);
        end
        tick();
        n_chk++;
        if (o_drop_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL drop_merge: got %0d expected 2", o_drop_cnt);
        end
        repeat (298) tick();
        i_btn_pulse = '0;
        n_chk++;
        if (o_drop_cnt !== 8'd255 || o_pending !== 5'b00001) begin
            n_fail++;
            $display("FAIL drop_sat: got drop=%0d pend=%b expected 255/00001", o_drop_cnt, o_pending);
        end
        i_cmd_ready = 1'b1;
        repeat (2 * GAP + 6) tick();
    endtask

    task automatic test_regrant();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_cmd_ready = 1'b0;
        i_btn_pulse = 5'b00100;
        tick();
        tick();
        i_btn_pulse = '0;
        n_chk++;
        if (o_cmd_valid !== 1'b1 || o_cmd_id !== 3'd2 || o_pending !== 5'b00100 || o_drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL regrant_first: got v=%0b id=%0d pend=%b drop=%0d expected 1/2/00100/0", o_cmd_valid, o_cmd_id, o_pending, o_drop_cnt);
        end
        i_cmd_ready = 1'b1;
        tick();
        wait_valid(n);
        n_chk++;
        if (n + 1 !== GAP + 2 || o_cmd_id !== 3'd2 || o_cmd_src !== 1'b0) begin
            n_fail++;
            $display("FAIL regrant_second: got gap=%0d id=%0d src=%0b expected %0d/2/0", n + 1, o_cmd_id, o_cmd_src, GAP + 2);
        end
        tick();
        n_chk++;
        if (o_pending !== 5'b0 || o_cmd_valid !== 1'b0 || o_drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL regrant_done: got pend=%b v=%0b drop=%0d expected 0/0/0", o_pending, o_cmd_valid, o_drop_cnt);
        end
        repeat (GAP + 2) tick();
    endtask

    task automatic test_reset_mid_gap();
        int n;
        i_cmd_ready = 1'b1;
        i_btn_pulse = 5'b01000;
        tick();
        i_btn_pulse = '0;
        tick();
        tick();
        i_btn_pulse = 5'b01001;
        tick();
        i_btn_pulse = '0;
        n_chk++;
        if (o_pending !== 5'b01001 || o_cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midgap_pend: got pend=%b v=%0b expected 01001/0", o_pending, o_cmd_valid);
        end
        tick();
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({o_cmd_valid, o_cmd_id, o_cmd_src} !== 5'b0 || o_pending !== 5'b0 || o_drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midgap_reset: got v=%0b id=%0d src=%0b pend=%b drop=%0d expected all 0", o_cmd_valid, o_cmd_id, o_cmd_src, o_pending, o_drop_cnt);
        end
        tick();
        rst = 1'b0;
        n = 0;
        repeat (30) begin
            tick();
            if (o_cmd_valid === 1'b1) n++;
        end
        n_chk++;
        if (n !== 0 || o_pending !== 5'b0) begin
            n_fail++;
            $display("FAIL midgap_quiet: got %0d valid cycles pend=%b expected 0/0", n, o_pending);
        end
    endtask

    initial begin
        test_reset();
        test_single_button();
        test_same_cycle();
        test_uart_hold();
        test_drop_sat();
        test_regrant();
        test_reset_mid_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
